// File: rtl/stream_cipher_pkg.sv
// Shared stream-cipher definitions: FSM states, default seed and LFSR feedback.
// Both the encryptor and decryptor use lfsr_next, so the two ends share one keystream.
package stream_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] SEED_DEFAULT = 8'hCD;
  localparam logic [7:0] TAP_MASK     = 8'hB8;

  // The feedback bit is the parity of the tapped bits 7, 5, 4 and 3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] k);
    return {k[6:0], ^(k & TAP_MASK)};
  endfunction

endpackage

// File: rtl/stream_lfsr8.sv
// 8-bit keystream LFSR. A load takes priority over an advance in the same cycle.
module stream_lfsr8
  import stream_cipher_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       adv,
  output logic [7:0] k
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    k <= SEED;
    else if (load) k <= load_val;
    else if (adv)  k <= lfsr_next(k);
  end

endmodule

// File: rtl/stream_decrypt_fsm.sv
// Stream-cipher decryptor: ciphertext XOR regenerated LFSR keystream, with a one-entry output register.
// Optional macro STREAM_DEC_ZERO_SEED_GUARD_EN replaces a zero seed with SEED and pulses seed_err.
module stream_decrypt_fsm
  import stream_cipher_pkg::*;
#(
  parameter logic [7:0] SEED  = SEED_DEFAULT,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [7:0]       seed_in,
  input  logic             start,
  input  logic             ct_valid,
  input  logic [7:0]       ct_data,
  input  logic             ct_last,
  output logic             ct_ready,
  output logic             pt_valid,
  output logic [7:0]       pt_data,
  output logic             pt_last,
  input  logic             pt_ready,
  output logic             busy,
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
  output logic             seed_err,
`endif
  output logic [CNT_W-1:0] byte_cnt
);

  state_t     state, state_nxt;
  logic [7:0] seed_reg, seed_eff, k, lfsr_val;
  logic       lfsr_load, seed_ld, cnt_clr, accept;

`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
  logic seed_zero;
  assign seed_zero = (seed_in == 8'h00);
  assign seed_eff  = seed_zero ? SEED : seed_in;
`else
  assign seed_eff  = seed_in;
`endif

  assign accept = ct_valid & ct_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ct_ready  = 1'b0;
    lfsr_load = 1'b0;
    lfsr_val  = seed_reg;
    seed_ld   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (seed_valid) begin
          seed_ld   = 1'b1;
          lfsr_load = 1'b1;
          lfsr_val  = seed_eff;
          cnt_clr   = 1'b1;
          state_nxt = RUN;
        end else if (start) begin
          lfsr_load = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ct_ready = !pt_valid || pt_ready;
        // Reload the seed on the last byte so the next frame decodes independently.
        if (ct_valid && ct_ready && ct_last) begin
          lfsr_load = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pt_valid && pt_ready && pt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  stream_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (lfsr_val),
    .adv      (accept),
    .k        (k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      seed_reg <= SEED;
      pt_valid <= 1'b0;
      pt_data  <= 8'h00;
      pt_last  <= 1'b0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (seed_ld) seed_reg <= seed_eff;
      if (cnt_clr)     byte_cnt <= '0;
      else if (accept) byte_cnt <= byte_cnt + 1'b1;
      if (accept) begin
        pt_valid <= 1'b1;
        pt_data  <= ct_data ^ k;
        pt_last  <= ct_last;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seed_err <= 1'b0;
    else        seed_err <= (state == IDLE) && seed_valid && seed_zero;
  end
`endif

endmodule

// File: tb/tb_stream_decrypt_fsm.sv
// Self-checking bench for stream_decrypt_fsm against an arithmetic keystream model.
module tb_stream_decrypt_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_valid = 1'b0, start = 1'b0;
  logic [7:0]  seed_in = 8'h00;
  logic        ct_valid = 1'b0, ct_last = 1'b0;
  logic [7:0]  ct_data = 8'h00;
  logic        ct_ready, pt_valid, pt_last, busy;
  logic [7:0]  pt_data;
  logic        pt_ready = 1'b1;
  logic [15:0] byte_cnt;
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
  logic        seed_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] m_seed = 8'hCD;
  logic [7:0] m_k    = 8'hCD;
  logic [7:0] ct_q[$];
  logic [7:0] rx_q[$];
  int         seed_err_cnt;

  stream_decrypt_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_in    (seed_in),
    .start      (start),
    .ct_valid   (ct_valid),
    .ct_data    (ct_data),
    .ct_last    (ct_last),
    .ct_ready   (ct_ready),
    .pt_valid   (pt_valid),
    .pt_data    (pt_data),
    .pt_last    (pt_last),
    .pt_ready   (pt_ready),
    .busy       (busy),
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
    .seed_err   (seed_err),
`endif
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Keystream step: shift left, feedback = parity of bits 7,5,4,3 (plain arithmetic).
  function automatic logic [7:0] ks_next(input logic [7:0] k);
    int v, fb;
    v  = int'(k);
    fb = ((v / 128) % 2 + (v / 32) % 2 + (v / 16) % 2 + (v / 8) % 2) % 2;
    return 8'((v * 2 + fb) % 256);
  endfunction

  // entry: 0=start, 1=seed_valid, 2=both. pmode: 0=ready high, 1=random, 2=low on cycles 3..6.
  task automatic run_frame(input int entry, input logic [7:0] sd, input int pmode,
                           input bit vrand, input bit mid_seed);
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] prev_data;
    bit         prev_hold;
    int         sent, got, cyc, n;
    n = ct_q.size(); sent = 0; got = 0; cyc = 0; prev_hold = 0; prev_data = 8'h00;
    rx_q.delete();
    seed_err_cnt = 0;
    @(negedge clk);
    start      = (entry != 1);
    seed_valid = (entry != 0);
    seed_in    = sd;
    ct_valid   = 1'b0;
    pt_ready   = 1'b1;
    if (seed_valid) begin
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
      m_seed = (sd == 8'h00) ? 8'hCD : sd;
`else
      m_seed = sd;
`endif
    end
    m_k = m_seed;
    while ((sent < n || got < n) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start      = 1'b0;
      seed_valid = mid_seed && (cyc == 2);
      seed_in    = 8'($urandom);
      ct_valid   = (sent < n) && (!vrand || $urandom_range(0, 3) != 0);
      ct_data    = (sent < n) ? ct_q[sent] : 8'($urandom);
      ct_last    = (sent == n - 1);
      pt_ready   = (pmode == 0) ? 1'b1 :
                   (pmode == 1) ? 1'($urandom_range(0, 1)) : !(cyc >= 3 && cyc <= 6);
      #1;
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
      if (seed_err) seed_err_cnt++;
`endif
      if (prev_hold) begin
        checks++;
        if (pt_valid !== 1'b1 || pt_data !== prev_data) begin
          errors++;
          $display("FAIL hold: pt_valid=%b pt_data=%h required valid=1 data=%h", pt_valid, pt_data, prev_data);
        end
      end
      if (pt_valid && !pt_ready) begin
        checks++;
        if (ct_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_ready: ct_ready=%b required 0", ct_ready);
        end
      end
      prev_hold = pt_valid && !pt_ready;
      prev_data = pt_data;
      if (pt_valid && pt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pt: got %h with nothing outstanding", pt_data);
        end else begin
          e = exp_q.pop_front();
          if ({pt_last, pt_data} !== e) begin
            errors++;
            $display("FAIL pt_byte%0d: last/data=%b/%h required %b/%h", got, pt_last, pt_data, e[8], e[7:0]);
          end
        end
        rx_q.push_back(pt_data);
        got++;
      end
      if (ct_valid && ct_ready) begin
        exp_q.push_back({ct_last, ct_data ^ m_k});
        m_k = ks_next(m_k);
        sent++;
      end
    end
    if (cyc >= 400) begin
      errors++;
      $display("FAIL frame_timeout: sent=%0d got=%0d required %0d", sent, got, n);
    end
    @(negedge clk);
    seed_valid = 1'b0;
    ct_valid   = 1'b0;
    pt_ready   = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || byte_cnt !== 16'(n)) begin
      errors++;
      $display("FAIL frame_end: busy=%b byte_cnt=%0d required 0/%0d", busy, byte_cnt, n);
    end
    m_k = m_seed;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (ct_ready !== 1'b0 || pt_valid !== 1'b0 || pt_data !== 8'h00 || pt_last !== 1'b0 ||
        busy !== 1'b0 || byte_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s: ct_ready=%b pt_valid=%b pt_data=%h pt_last=%b busy=%b byte_cnt=%0d required all 0",
               tag, ct_ready, pt_valid, pt_data, pt_last, busy, byte_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] want[3] = '{8'hCD, 8'h9A, 8'h35};
    ct_q = '{8'h00, 8'h00, 8'h00};
    run_frame(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== want[i]) begin
        errors++;
        $display("FAIL basic_pt%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_seed01();
    ct_q = '{8'h00, 8'h00};
    run_frame(1, 8'h01, 0, 0, 0);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
      errors++;
      $display("FAIL seed01: got %p required 01 02", rx_q);
    end
  endtask

  task automatic test_back_pressure();
    ct_q.delete();
    for (int i = 0; i < 10; i++) ct_q.push_back(8'($urandom));
    run_frame(0, 8'h00, 2, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] first[$];
    ct_q.delete();
    for (int i = 0; i < 6; i++) ct_q.push_back(8'($urandom));
    run_frame(0, 8'h00, 1, 1, 0);
    first = rx_q;
    run_frame(0, 8'h00, 1, 1, 0);
    checks++;
    if (first != rx_q) begin
      errors++;
      $display("FAIL restart: second frame %p required %p", rx_q, first);
    end
  endtask

  task automatic test_seed_start();
    ct_q = '{8'h00, 8'h11, 8'h22, 8'h33};
    run_frame(2, 8'h5A, 0, 0, 1);
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL seed_and_start: first pt %h required 5a", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    ct_q = '{8'h00};
    run_frame(0, 8'h00, 0, 0, 0);
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL seed_in_run_ignored: first pt %h required 5a", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      ct_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) ct_q.push_back(8'($urandom));
      run_frame(int'($urandom_range(0, 2)), 8'($urandom_range(1, 255)), 1, 1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_zero_seed();
    ct_q = '{8'h00, 8'h00};
    run_frame(1, 8'h00, 0, 0, 0);
`ifdef STREAM_DEC_ZERO_SEED_GUARD_EN
    checks++;
    if (seed_err_cnt != 1 || rx_q.size() == 0 || rx_q[0] !== 8'hCD) begin
      errors++;
      $display("FAIL zero_seed_guard: seed_err pulses=%0d first pt=%p required 1 pulse, cd", seed_err_cnt, rx_q);
    end
`else
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'h00) begin
      errors++;
      $display("FAIL zero_seed_passthru: got %p required 00 00", rx_q);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ct_valid = 1'b1;
    ct_data  = 8'hA5;
    ct_last  = 1'b0;
    pt_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pt_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_setup: pt_valid=%b busy=%b required 1/1", pt_valid, busy);
    end
    rst_n    = 1'b0;
    ct_valid = 1'b0;
    #1;
    check_reset_outputs("reset_midframe");
    @(negedge clk);
    rst_n    = 1'b1;
    pt_ready = 1'b1;
    m_seed   = 8'hCD;
    m_k      = 8'hCD;
    ct_q = '{8'h00, 8'h0F};
    run_frame(0, 8'h00, 0, 0, 0);
    checks++;
    if (rx_q.size() == 0 || rx_q[0] !== 8'hCD) begin
      errors++;
      $display("FAIL post_reset_seed: first pt %h required cd", (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed01();
    test_back_pressure();
    test_back_to_back();
    test_seed_start();
    test_random();
    test_zero_seed();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_decrypt_fsm.md
# stream_decrypt_fsm

Receive-side counterpart of the stream-cipher keystream encryptor. Accepts ciphertext bytes over a valid/ready stream, regenerates the identical 8-bit LFSR keystream, and emits plaintext as ciphertext XOR keystream. Seed load, frame start/end and back-pressure are sequenced by a small FSM. On each frame end the keystream restarts from the stored seed, so frames decode independently.

## Interface
- SEED, 8'hCD, default seed for the seed register and LFSR after reset
- CNT_W, 16, width of the accepted-byte counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seed_valid  in  1  load seed_in into seed register and LFSR (IDLE only)
- seed_in  in  8  seed value
- start  in  1  begin a frame using the stored seed (IDLE only)
- ct_valid  in  1  ciphertext byte valid
- ct_data  in  8  ciphertext byte
- ct_last  in  1  marks last byte of frame, qualified by ct_valid
- ct_ready  out  1  decryptor can accept a byte
- pt_valid  out  1  plaintext byte valid
- pt_data  out  8  plaintext byte
- pt_last  out  1  last plaintext byte of frame
- pt_ready  in  1  downstream accepts plaintext
- busy  out  1  FSM not in IDLE
- byte_cnt  out  CNT_W  bytes accepted in current frame

## Operation
- Keystream byte = current LFSR state k. Advance: k <= {k[6:0], k[7]^k[5]^k[4]^k[3]}. Exactly one advance per accepted ciphertext byte, none otherwise.
- Accept = ct_valid & ct_ready. On accept: pt_data <= ct_data ^ k, pt_last <= ct_last, pt_valid <= 1, k advances, byte_cnt increments (wraps modulo 2^CNT_W).
- Output register is a single entry: ct_ready = (state==RUN) & (!pt_valid | pt_ready). pt_valid clears on pt_valid & pt_ready with no same-cycle accept.
- FSM states:
  - IDLE: ct_ready=0. seed_valid -> seed_reg<=seed_in, k<=seed_in, byte_cnt<=0, go RUN. Otherwise start -> k<=seed_reg, byte_cnt<=0, go RUN. seed_valid and start in the same cycle -> seed load wins, single entry to RUN.
  - RUN: accept bytes. Accept with ct_last=1 -> go DRAIN.
  - DRAIN: ct_ready=0. k<=seed_reg on entry. When the last byte handshakes (pt_valid & pt_ready & pt_last) -> IDLE.
- seed_valid and start are ignored outside IDLE; seed_reg is unchanged.
- Reset mid-frame: all state returns to reset values immediately; any in-flight output byte is discarded.

## Timing
- Reset values: state=IDLE, seed_reg=SEED, k=SEED, ct_ready=0, pt_valid=0, pt_data=0, pt_last=0, busy=0, byte_cnt=0.
- Latency: plaintext appears with pt_valid the cycle after accept.
- Throughput: 1 byte/cycle with pt_ready held high.
- pt_data and pt_last remain stable while pt_valid=1 and pt_ready=0.
- ct_ready is combinational from state, pt_valid and pt_ready. There is no combinational path from ct_* to pt_*.
- IDLE -> RUN takes 1 cycle. ct_ready can assert on the cycle after seed_valid or start.

## Configuration
- STREAM_DEC_ZERO_SEED_GUARD_EN:
  - Defined: seed_valid with seed_in==8'h00 loads SEED instead and pulses output seed_err (1 cycle, reset 0). This prevents LFSR lockup at zero.
  - Undefined: zero is loaded as given, the keystream stays 0 (plaintext = ciphertext), and the seed_err port is absent.

## Structure
- Shared package stream_cipher_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - default SEED constant
  - tap mask 8'hB8
  - lfsr_next function, shared with the encryptor so both ends use one feedback definition
- One sub-module: stream_lfsr8 (seed load, advance enable, state output). The FSM and output register live in the top.

## Test plan
- Reset, start, ct 8'h00 x3 with ct_last on the third byte, pt_ready=1 -> pt_data CD, 9A, 35; pt_last on 35; byte_cnt=3; returns to IDLE.
- seed_valid seed_in=8'h01, then ct 8'h00, 8'h00 -> pt 01, 02.
- Back-pressure: pt_ready=0 for 4 cycles mid-frame -> ct_ready=0, pt_data held, no LFSR advance, no lost or duplicated bytes after release.
- Frame restart: two frames back-to-back via start with identical ciphertext -> identical plaintext (keystream reloaded from seed_reg).
- seed_valid and start asserted in the same IDLE cycle with seed 8'h5A -> first key byte 5A. seed_valid during RUN -> ignored, seed_reg unchanged.
- With STREAM_DEC_ZERO_SEED_GUARD_EN defined: seed 8'h00 -> seed_err pulses once, first pt for ct 00 is CD. rst_n asserted mid-frame -> all outputs at reset values the same cycle.
